busca_instrucao: RTL and testbench
==================================

// Module: busca_instrucao
// PURPOSE
//  Instruction sequencer that sits in front of unidade_controle and drives its Run/Done handshake.
//  - Fetches 9-bit instructions, plus a 16-bit immediate for mvi, from a synchronous-read program memory.
//  - Presents Instrucao/DIN to the datapath and pulses Run.
//  - Waits for Done, then advances the PC.
//  - Stops on the halt opcode, or on a Done timeout.
// PARAMETERS
//  ADDR_W        5    program memory address width; PC wraps modulo 2**ADDR_W
//  DATA_W        16   memory word / DIN width; instruction is MemData[8:0]
//  DONE_TIMEOUT  15   max cycles in ESPERA_DONE before error
// PORTS
//  Clock      in   1       single clock; all state updates on rising edge
//  Resetn     in   1       asynchronous, active-high reset (name kept for consistency)
//  Start      in   1       level; sampled in OCIOSO/PARADO; begins execution at PC=0
//  MemAddr    out  ADDR_W  program memory address (combinational from state/PC)
//  MemData    in   DATA_W  memory read data, valid the cycle after MemAddr is presented
//  Instrucao  out  9       instruction to unidade_controle; held stable from Run until Done
//  DIN        out  DATA_W  mvi immediate; held like Instrucao; 0 for non-mvi
//  Run        out  1       exactly one-cycle pulse per instruction
//  Done       in   1       from unidade_controle; honoured only in ESPERA_DONE
//  PC         out  ADDR_W  address of current instruction (debug)
//  Busy       out  1       1 in every state except OCIOSO and PARADO
//  Halted     out  1       1 in PARADO
//  Erro       out  1       sticky; set on Done timeout, cleared by Start or reset
// BEHAVIOUR
//  Reset: state=OCIOSO.
//   - Outputs: PC, Instrucao, DIN, Run, Busy, Halted and Erro all 0; MemAddr=0; timeout counter 0.
//  States and transitions:
//   - OCIOSO: Start=1 -> BUSCA_I, PC=0.
//   - BUSCA_I: MemAddr=PC -> LE_I.
//   - LE_I: Instrucao<=MemData[8:0]. If MemData[8:6]==OP_HALT -> PARADO. If OP_MVI -> BUSCA_D. Else DIN<=0 -> EMITE.
//   - BUSCA_D: MemAddr=PC+1 (mod 2**ADDR_W) -> LE_D.
//   - LE_D: DIN<=MemData -> EMITE.
//   - EMITE: Run=1 for this single cycle; timeout counter cleared -> ESPERA_DONE.
//   - ESPERA_DONE: on Done=1, PC<=PC+1 (PC+2 for mvi, modulo) -> BUSCA_I.
//  Timeout: counter increments each cycle without Done. When it reaches DONE_TIMEOUT: Erro<=1 -> PARADO, PC unchanged.
//  PARADO: Halted=1. Start=1 -> BUSCA_I, PC=0, Erro<=0.
//  Latency: Start sampled at edge k -> Run high in cycle k+3 (non-mvi) or k+5 (mvi).
//   - Done sampled at edge j -> next Run at j+3 / j+5.
//  Boundaries:
//   - Done outside ESPERA_DONE is ignored, including a Done coincident with Run in EMITE.
//   - Start while Busy is ignored.
//   - mvi at address 2**ADDR_W-1 takes its immediate from address 0. PC wraps to 0 after the last word.
//   - Done and the timeout expiry in the same cycle: Done wins, no error.
//   - Reset mid-operation (any state, including Run high) forces the reset values immediately.
//  Instrucao/DIN change only in LE_I/LE_D, never while in EMITE or ESPERA_DONE.
// STRUCTURE
//  Shared package/include (uc_defs):
//   - opcodes OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_MVNZ=100, OP_HALT=111
//   - FSM state encodings
//  Sub-module contador_programa: ADDR_W register with synchronous clear, +1/+2 increment and async reset.
//  The FSM and timeout counter live in this module.
// TESTING
//  - Mem[0]=mv R1,R0; Mem[1]=halt. Start pulse; Done 2 cycles after Run -> one Run with Instrucao=9'o010, DIN=0, then Halted=1, PC=1.
//  - Mem[0]=mvi R2 (9'o120); Mem[1]=16'h00A5; Mem[2]=halt -> Run at k+5 with DIN=16'h00A5; after Done PC=2, then Halted.
//  - Done never returned -> exactly DONE_TIMEOUT cycles after Run: Erro=1, Halted=1, PC=0. Start -> Erro=0, refetch from 0.
//  - Done pulsed during BUSCA_I and EMITE -> ignored, no PC change. Start held during Busy -> no restart.
//  - ADDR_W=2, mvi at addr 3 with Mem[0]=imm -> DIN=Mem[0], PC wraps to 1 after Done.
//  - Resetn asserted in ESPERA_DONE with Run just pulsed -> all outputs 0 asynchronously; no Run until a new Start.

Source files
------------

// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// the instruction word layout handed to unidade_controle.
package busca_instrucao_pkg;

   localparam int unsigned INSTR_W = 9;
   localparam int unsigned OP_W    = 3;

   localparam logic [OP_W-1:0] OP_MV   = 3'b000;
   localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
   localparam logic [OP_W-1:0] OP_MVNZ = 3'b100;
   localparam logic [OP_W-1:0] OP_HALT = 3'b111;

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      BUSCA_I     = 3'd1,
      LE_I        = 3'd2,
      BUSCA_D     = 3'd3,
      LE_D        = 3'd4,
      EMITE       = 3'd5,
      ESPERA_DONE = 3'd6,
      PARADO      = 3'd7
   } estado_t;

   // Instruction word: opcode followed by the two register fields
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [2:0]      rx;
      logic [2:0]      ry;
   } instrucao_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Bus between the sequencer, its program memory and unidade_controle.
// master = sequencer side, slave = memory / datapath / host side.
interface busca_instrucao_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 16
);
   import busca_instrucao_pkg::*;

   logic                Start;
   logic [ADDR_W-1:0]   MemAddr;
   logic [DATA_W-1:0]   MemData;
   logic [INSTR_W-1:0]  Instrucao;
   logic [DATA_W-1:0]   DIN;
   logic                Run;
   logic                Done;
   logic [ADDR_W-1:0]   PC;
   logic                Busy;
   logic                Halted;
   logic                Erro;

   modport master (
      input  Start, MemData, Done,
      output MemAddr, Instrucao, DIN, Run, PC, Busy, Halted, Erro
   );

   modport slave (
      output Start, MemData, Done,
      input  MemAddr, Instrucao, DIN, Run, PC, Busy, Halted, Erro
   );

endinterface

// File: rtl/busca_instrucao_contador_programa.sv
// Program counter: synchronous clear, +1 / +2 step, wraps modulo 2**ADDR_W.
module contador_programa #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc1,
   input  logic              inc2,
   output logic [ADDR_W-1:0] pc
);

   // Clear has priority; +2 skips over an mvi immediate word
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pc <= '0;
      else if (clr)  pc <= '0;
      else if (inc2) pc <= pc + ADDR_W'(2);
      else if (inc1) pc <= pc + ADDR_W'(1);
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction sequencer in front of unidade_controle: fetches instructions
// (plus the mvi immediate), pulses Run, waits for Done and advances the PC.
// Stops on halt or when Done does not arrive within DONE_TIMEOUT cycles.
module busca_instrucao
   import busca_instrucao_pkg::*;
#(
   parameter int unsigned ADDR_W       = 5,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned DONE_TIMEOUT = 15
) (
   input  logic               Clock,
   input  logic               Resetn,
   busca_instrucao_if.master  bus
);

   localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);

   estado_t           estado, estado_n;
   instrucao_t        instr_q, instr_n;
   logic [DATA_W-1:0] din_q, din_n;
   logic              erro_q, erro_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic              pc_clr, pc_inc1, pc_inc2;
   logic [ADDR_W-1:0] pc;

   contador_programa #(.ADDR_W(ADDR_W)) u_pc (
      .clk  (Clock),
      .rst  (Resetn),
      .clr  (pc_clr),
      .inc1 (pc_inc1),
      .inc2 (pc_inc2),
      .pc   (pc)
   );

   // State and held datapath-facing registers
   always_ff @(posedge Clock or posedge Resetn) begin
      if (Resetn) begin
         estado  <= OCIOSO;
         instr_q <= '0;
         din_q   <= '0;
         erro_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         estado  <= estado_n;
         instr_q <= instr_n;
         din_q   <= din_n;
         erro_q  <= erro_n;
         cnt_q   <= cnt_n;
      end
   end

   // Next-state, register updates and PC control
   always_comb begin
      estado_n = estado;
      instr_n  = instr_q;
      din_n    = din_q;
      erro_n   = erro_q;
      cnt_n    = cnt_q;
      pc_clr   = 1'b0;
      pc_inc1  = 1'b0;
      pc_inc2  = 1'b0;
      case (estado)
         OCIOSO: begin
            if (bus.Start) begin
               estado_n = BUSCA_I;
               pc_clr   = 1'b1;
            end
         end
         BUSCA_I: estado_n = LE_I;
         LE_I: begin
            instr_n = instrucao_t'(bus.MemData[INSTR_W-1:0]);
            if (instr_n.op == OP_HALT) begin
               estado_n = PARADO;
            end else if (instr_n.op == OP_MVI) begin
               estado_n = BUSCA_D;
            end else begin
               din_n    = '0;
               estado_n = EMITE;
            end
         end
         BUSCA_D: estado_n = LE_D;
         LE_D: begin
            din_n    = bus.MemData;
            estado_n = EMITE;
         end
         EMITE: begin
            cnt_n    = '0;
            estado_n = ESPERA_DONE;
         end
         ESPERA_DONE: begin
            // Done is checked first so it wins over a coincident expiry
            if (bus.Done) begin
               estado_n = BUSCA_I;
               if (instr_q.op == OP_MVI) pc_inc2 = 1'b1;
               else                      pc_inc1 = 1'b1;
            end else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
               erro_n   = 1'b1;
               estado_n = PARADO;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         PARADO: begin
            if (bus.Start) begin
               estado_n = BUSCA_I;
               pc_clr   = 1'b1;
               erro_n   = 1'b0;
            end
         end
         default: estado_n = OCIOSO;
      endcase
   end

   // Memory address follows the state: immediate word sits right after the mvi
   assign bus.MemAddr   = (estado == BUSCA_D) ? pc + ADDR_W'(1) : pc;
   assign bus.Instrucao = instr_q;
   assign bus.DIN       = din_q;
   assign bus.Run       = (estado == EMITE);
   assign bus.PC        = pc;
   assign bus.Busy      = (estado != OCIOSO) && (estado != PARADO);
   assign bus.Halted    = (estado == PARADO);
   assign bus.Erro      = erro_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a 32-word and a 4-word program memory,
// Run events scored against an expectation queue by per-DUT monitors.
module tb_busca_instrucao;
   import busca_instrucao_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   busca_instrucao_if #(.ADDR_W(5), .DATA_W(16)) b5 ();
   busca_instrucao_if #(.ADDR_W(2), .DATA_W(16)) b2 ();

   busca_instrucao #(.ADDR_W(5), .DATA_W(16), .DONE_TIMEOUT(15)) u5 (
      .Clock(clk), .Resetn(rst), .bus(b5));
   busca_instrucao #(.ADDR_W(2), .DATA_W(16), .DONE_TIMEOUT(15)) u2 (
      .Clock(clk), .Resetn(rst), .bus(b2));

   logic [15:0] mem5 [32];
   logic [15:0] mem2 [4];

   // Synchronous-read program memories
   always @(posedge clk) b5.MemData <= mem5[b5.MemAddr];
   always @(posedge clk) b2.MemData <= mem2[b2.MemAddr];

   typedef struct {
      logic [8:0]  instr;
      logic [15:0] din;
      logic [4:0]  pc;
   } esp_t;

   esp_t q5[$];
   esp_t q2[$];
   int checks = 0;
   int errors = 0;

   // Scoreboard monitor, wide DUT
   always @(negedge clk) begin : mon5
      esp_t e;
      if (b5.Run) begin
         checks++;
         if (q5.size() == 0) begin
            errors++;
            $display("FAIL run5: unexpected Run instr=%o din=%h pc=%0d", b5.Instrucao, b5.DIN, b5.PC);
         end else begin
            e = q5.pop_front();
            if (b5.Instrucao !== e.instr || b5.DIN !== e.din || b5.PC !== e.pc) begin
               errors++;
               $display("FAIL run5: got instr=%o din=%h pc=%0d required instr=%o din=%h pc=%0d",
                        b5.Instrucao, b5.DIN, b5.PC, e.instr, e.din, e.pc);
            end
         end
      end
   end

   // Scoreboard monitor, 2-bit address DUT
   always @(negedge clk) begin : mon2
      esp_t e;
      if (b2.Run) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL run2: unexpected Run instr=%o din=%h pc=%0d", b2.Instrucao, b2.DIN, b2.PC);
         end else begin
            e = q2.pop_front();
            if (b2.Instrucao !== e.instr || b2.DIN !== e.din || {3'b000, b2.PC} !== e.pc) begin
               errors++;
               $display("FAIL run2: got instr=%o din=%h pc=%0d required instr=%o din=%h pc=%0d",
                        b2.Instrucao, b2.DIN, b2.PC, e.instr, e.din, e.pc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic expect_run(input int sel, input logic [8:0] instr, input logic [15:0] din,
                             input logic [4:0] pc);
      esp_t e;
      e.instr = instr;
      e.din   = din;
      e.pc    = pc;
      if (sel == 0) q5.push_back(e);
      else          q2.push_back(e);
   endtask

   task automatic pulse_start(input int sel);
      if (sel == 0) b5.Start = 1'b1; else b2.Start = 1'b1;
      tick(1);
      if (sel == 0) b5.Start = 1'b0; else b2.Start = 1'b0;
   endtask

   // Waits for Run within a bounded budget and checks the latency
   task automatic wait_run(input int sel, input int exp_n, input string name);
      int   n;
      logic r;
      n = 0;
      r = 1'b0;
      do begin
         tick(1);
         n++;
         r = (sel == 0) ? b5.Run : b2.Run;
      end while (!r && n < 40);
      checks++;
      if (!r) begin
         errors++;
         $display("FAIL %s: no Run within %0d cycles", name, n);
      end else if (n != exp_n) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", name, n, exp_n);
      end
   endtask

   // Done pulse for one cycle after the given delay
   task automatic respond(input int sel, input int dly);
      tick(dly);
      if (sel == 0) b5.Done = 1'b1; else b2.Done = 1'b1;
      tick(1);
      if (sel == 0) b5.Done = 1'b0; else b2.Done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      b5.Start = 1'b0; b5.Done = 1'b0;
      b2.Start = 1'b0; b2.Done = 1'b0;
      for (int i = 0; i < 32; i++) mem5[i] = 16'h0000;
      for (int i = 0; i < 4; i++)  mem2[i] = 16'h0000;

      // Reset state
      rst = 1'b1;
      tick(2);
      chk("reset pc",     64'(b5.PC), 64'd0);
      chk("reset instr",  64'(b5.Instrucao), 64'd0);
      chk("reset flags",  64'({b5.Run, b5.Busy, b5.Halted, b5.Erro}), 64'd0);
      chk("reset memaddr", 64'(b5.MemAddr), 64'd0);
      rst = 1'b0;
      tick(1);

      // mv then halt, Done two cycles after Run
      mem5[0] = 16'o010;
      mem5[1] = 16'o700;
      expect_run(0, 9'o010, 16'h0000, 5'd0);
      pulse_start(0);
      wait_run(0, 2, "t1 run");
      respond(0, 2);
      tick(2);
      chk("t1 halted", 64'(b5.Halted), 64'd1);
      chk("t1 pc",     64'(b5.PC), 64'd1);
      chk("t1 busy",   64'(b5.Busy), 64'd0);
      chk("t1 instr",  64'(b5.Instrucao), 64'o700);

      // mvi with immediate
      mem5[0] = 16'o120;
      mem5[1] = 16'h00A5;
      mem5[2] = 16'o700;
      expect_run(0, 9'o120, 16'h00A5, 5'd0);
      pulse_start(0);
      wait_run(0, 4, "t2 run");
      respond(0, 1);
      chk("t2 pc after done", 64'(b5.PC), 64'd2);
      tick(2);
      chk("t2 halted", 64'(b5.Halted), 64'd1);
      chk("t2 pc",     64'(b5.PC), 64'd2);

      // Done never returned
      mem5[0] = 16'o010;
      mem5[1] = 16'o700;
      expect_run(0, 9'o010, 16'h0000, 5'd0);
      pulse_start(0);
      wait_run(0, 2, "t3 run");
      tick(15);
      chk("t3 before expiry", 64'({b5.Erro, b5.Busy}), 64'b01);
      tick(1);
      chk("t3 expiry", 64'({b5.Erro, b5.Halted, b5.Busy}), 64'b110);
      chk("t3 pc",     64'(b5.PC), 64'd0);
      // Restart clears Erro; Done on the last allowed cycle wins
      expect_run(0, 9'o010, 16'h0000, 5'd0);
      pulse_start(0);
      chk("t3 erro cleared", 64'({b5.Erro, b5.Busy}), 64'b01);
      wait_run(0, 2, "t3 rerun");
      tick(15);
      b5.Done = 1'b1;
      tick(1);
      b5.Done = 1'b0;
      chk("t3 done wins", 64'({b5.Erro, b5.Busy}), 64'b01);
      chk("t3 done wins pc", 64'(b5.PC), 64'd1);
      tick(2);
      chk("t3 halt after", 64'({b5.Halted, b5.Erro}), 64'b10);

      // Done outside ESPERA_DONE ignored, Start held while busy ignored
      mem5[0] = 16'o010;
      mem5[1] = 16'o234;
      mem5[2] = 16'o700;
      expect_run(0, 9'o010, 16'h0000, 5'd0);
      expect_run(0, 9'o234, 16'h0000, 5'd1);
      b5.Start = 1'b1;
      tick(1);
      b5.Done = 1'b1;
      tick(1);
      b5.Done = 1'b0;
      chk("t4 done in busca_i", 64'(b5.PC), 64'd0);
      wait_run(0, 1, "t4 run0");
      b5.Done = 1'b1;
      tick(1);
      b5.Done = 1'b0;
      chk("t4 done with run", 64'({b5.Busy, b5.PC}), 64'({1'b1, 5'd0}));
      tick(3);
      chk("t4 start held", 64'({b5.Busy, b5.PC}), 64'({1'b1, 5'd0}));
      respond(0, 0);
      chk("t4 pc advance", 64'(b5.PC), 64'd1);
      wait_run(0, 2, "t4 run1");
      respond(0, 1);
      b5.Start = 1'b0;
      tick(2);
      chk("t4 halted", 64'({b5.Halted, b5.PC}), 64'({1'b1, 5'd2}));

      // ADDR_W=2: mvi at the last address reads its immediate from address 0
      mem2[0] = 16'h1234;
      mem2[1] = 16'o010;
      mem2[2] = 16'o234;
      mem2[3] = 16'o120;
      expect_run(1, 9'h034, 16'h0000, 5'd0);
      expect_run(1, 9'o010, 16'h0000, 5'd1);
      expect_run(1, 9'o234, 16'h0000, 5'd2);
      expect_run(1, 9'o120, 16'h1234, 5'd3);
      pulse_start(1);
      wait_run(1, 2, "t5 run0");
      respond(1, 1);
      wait_run(1, 2, "t5 run1");
      mem2[1] = 16'o700;
      respond(1, 1);
      wait_run(1, 2, "t5 run2");
      respond(1, 1);
      wait_run(1, 4, "t5 run3");
      respond(1, 1);
      chk("t5 pc wrap", 64'(b2.PC), 64'd1);
      tick(2);
      chk("t5 halted", 64'({b2.Halted, b2.PC}), 64'({1'b1, 2'd1}));

      // Reset while waiting for Done
      mem5[0] = 16'o120;
      mem5[1] = 16'hBEEF;
      mem5[2] = 16'o700;
      expect_run(0, 9'o120, 16'hBEEF, 5'd0);
      pulse_start(0);
      wait_run(0, 4, "t6 run");
      tick(1);
      chk("t6 din held", 64'(b5.DIN), 64'hBEEF);
      rst = 1'b1;
      #1;
      chk("t6 async instr/din", 64'({b5.Instrucao, b5.DIN}), 64'd0);
      chk("t6 async flags", 64'({b5.Run, b5.Busy, b5.Halted, b5.Erro}), 64'd0);
      chk("t6 async pc/addr", 64'({b5.PC, b5.MemAddr}), 64'd0);
      tick(1);
      rst = 1'b0;
      respond(0, 1);
      tick(10);
      chk("t6 idle", 64'({b5.Busy, b5.Halted}), 64'd0);

      chk("queue5 drained", 64'(q5.size()), 64'd0);
      chk("queue2 drained", 64'(q2.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
